// File: rtl/aes_round_sequencer_if.sv
// Bundle of all block-level signals between the AES round sequencer and its
// neighbours: input handshake, round-key lookup, round datapath, output handshake.
// Modports:
//   slave  - the sequencer (accepts blocks, drives datapath/key index, presents ciphertext)
//   master - the surrounding logic (source, key store, round datapath, consumer)
// Optional abort signal exists only when AES_ABORT_EN is defined.
interface aes_round_sequencer_if #(
  parameter int RIDX_W = 4
);
  // Input block handshake
  logic              in_valid;
  logic              in_ready;
  logic [127:0]      in_block;
  // Round-key store lookup (combinational, same cycle)
  logic [RIDX_W-1:0] rk_idx;
  logic [127:0]      rk_data;
  // External combinational round datapath
  logic [127:0]      dp_state;
  logic              dp_final;
  logic [127:0]      dp_result;
  // Ciphertext handshake
  logic              out_valid;
  logic              out_ready;
  logic [127:0]      out_block;
`ifdef AES_ABORT_EN
  logic              abort;
`endif

  modport slave (
    input  in_valid, in_block, rk_data, dp_result, out_ready,
    output in_ready, rk_idx, dp_state, dp_final, out_valid, out_block
`ifdef AES_ABORT_EN
    , input abort
`endif
  );

  modport master (
    output in_valid, in_block, rk_data, dp_result, out_ready,
    input  in_ready, rk_idx, dp_state, dp_final, out_valid, out_block
`ifdef AES_ABORT_EN
    , output abort
`endif
  );
endinterface

// File: rtl/aes_round_sequencer.sv
// Purpose: iterative AES encrypt controller; owns state reg, round counter, key index, final-round select.
// Latency: ciphertext valid NR+1 cycles after the accept cycle; one block per NR+1 cycles at full rate.
// Backpressure: out_block held while out_ready=0; in_ready low during rounds, follows out_ready in DONE.
//
// Ports:
//   clk    - rising-edge clock
//   rst_n  - asynchronous active-low reset (release synchronous to clk)
//   bus    - aes_round_sequencer_if.slave:
//            in_valid/in_ready/in_block     plaintext handshake (S0 in [127:120], column-major)
//            rk_idx -> rk_data              round-key lookup, combinational same cycle
//            dp_state/dp_final -> dp_result external round datapath, combinational
//            out_valid/out_ready/out_block  ciphertext handshake (out_block = state register)
//            abort                          present only with AES_ABORT_EN
// Configuration macro: AES_ABORT_EN - adds the abort input; abort in ROUND/DONE discards the
//   block in flight and returns to IDLE on the next edge. Default build has no abort.
module aes_round_sequencer #(
  parameter int NR     = 10,  // rounds: 10/12/14 for AES-128/192/256
  parameter int RIDX_W = 4    // round counter / key index width, must hold NR
) (
  input  logic                    clk,
  input  logic                    rst_n,
  aes_round_sequencer_if.slave    bus
);

  localparam logic [RIDX_W-1:0] LAST_ROUND = RIDX_W'(NR);
  localparam logic [RIDX_W-1:0] ROUND_ONE  = RIDX_W'(1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ROUND = 2'd1,
    S_DONE  = 2'd2
  } fsm_t;

  fsm_t              fsm_q, fsm_d;
  logic [RIDX_W-1:0] round_q, round_d;
  logic [127:0]      state_q, state_d;
  logic              abort_req;
  logic              last_round;

`ifdef AES_ABORT_EN
  assign abort_req = bus.abort;
`else
  assign abort_req = 1'b0;
`endif

  // The round counter only ever runs 1..NR while in ROUND, so this compare
  // selects the final (no-MixColumns) round.
  assign last_round = (round_q == LAST_ROUND);

  // The datapath always sees the live state; the ciphertext is the same register.
  assign bus.dp_state  = state_q;
  assign bus.out_block = state_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_q   <= S_IDLE;
      round_q <= '0;
      state_q <= '0;
    end else begin
      fsm_q   <= fsm_d;
      round_q <= round_d;
      state_q <= state_d;
    end
  end

  always_comb begin
    fsm_d         = fsm_q;
    round_d       = round_q;
    state_d       = state_q;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    bus.rk_idx    = '0;
    bus.dp_final  = 1'b0;

    unique case (fsm_q)
      S_IDLE: begin
        // rk_idx is 0 here, so rk_data is the whitening key for round-0 AddRoundKey.
        bus.in_ready = 1'b1;
        if (bus.in_valid) begin
          state_d = bus.in_block ^ bus.rk_data;
          round_d = ROUND_ONE;
          fsm_d   = S_ROUND;
        end
      end

      S_ROUND: begin
        bus.rk_idx   = round_q;
        bus.dp_final = last_round;
        if (abort_req) begin
          // Drop the block; state is left as is since out_valid stays low.
          round_d = '0;
          fsm_d   = S_IDLE;
        end else begin
          state_d = bus.dp_result;
          if (last_round) begin
            round_d = '0;
            fsm_d   = S_DONE;
          end else begin
            round_d = round_q + ROUND_ONE;
          end
        end
      end

      S_DONE: begin
        bus.out_valid = 1'b1;
        // Re-accept is only possible on the cycle the ciphertext leaves, and
        // never while an abort is pending.
        bus.in_ready  = bus.out_ready & ~abort_req;
        if (abort_req) begin
          fsm_d = S_IDLE;
        end else if (bus.out_ready) begin
          if (bus.in_valid) begin
            state_d = bus.in_block ^ bus.rk_data;
            round_d = ROUND_ONE;
            fsm_d   = S_ROUND;
          end else begin
            fsm_d = S_IDLE;
          end
        end
      end

      default: begin
        round_d = '0;
        fsm_d   = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_aes_round_sequencer.sv
// Bench for aes_round_sequencer: supplies an AES-128 key store and round datapath,
// scoreboards ciphertext against a reference encryptor, and checks handshake timing.
module tb_aes_round_sequencer;
  localparam int NR     = 10;
  localparam int RIDX_W = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   cyc   = 0;
  int   n_chk = 0;
  int   n_pass = 0;

  aes_round_sequencer_if #(.RIDX_W(RIDX_W)) bus ();

  aes_round_sequencer #(.NR(NR), .RIDX_W(RIDX_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", tag, obs, exp);
  endtask

  // ---------------- AES-128 reference pieces ----------------
  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, aa, bb;
    p = 8'h00; aa = a; bb = b;
    for (int i = 0; i < 8; i++) begin
      if (bb[0]) p = p ^ aa;
      aa = xt(aa);
      bb = bb >> 1;
    end
    return p;
  endfunction

  // S-box from GF(2^8) inverse (x^254) followed by the affine map.
  function automatic logic [7:0] sb(input logic [7:0] x);
    logic [7:0] p, v;
    p = x; v = 8'h01;
    for (int i = 0; i < 7; i++) begin
      p = gmul(p, p);
      v = gmul(v, p);
    end
    return v ^ {v[6:0], v[7]} ^ {v[5:0], v[7:6]} ^ {v[4:0], v[7:5]} ^ {v[3:0], v[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [127:0] aes_round(input logic [127:0] s, input logic [127:0] k,
                                             input logic fin);
    logic [7:0]   a [16];
    logic [7:0]   b [16];
    logic [7:0]   x0, x1, x2, x3;
    logic [127:0] r;
    for (int i = 0; i < 16; i++) a[i] = sb(s[127-8*i -: 8]);
    for (int c = 0; c < 4; c++)
      for (int rw = 0; rw < 4; rw++) b[rw+4*c] = a[rw+4*((c+rw)%4)];
    if (!fin) begin
      for (int c = 0; c < 4; c++) begin
        x0 = b[4*c]; x1 = b[4*c+1]; x2 = b[4*c+2]; x3 = b[4*c+3];
        b[4*c]   = xt(x0) ^ xt(x1) ^ x1 ^ x2 ^ x3;
        b[4*c+1] = x0 ^ xt(x1) ^ xt(x2) ^ x2 ^ x3;
        b[4*c+2] = x0 ^ x1 ^ xt(x2) ^ xt(x3) ^ x3;
        b[4*c+3] = xt(x0) ^ x0 ^ x1 ^ x2 ^ xt(x3);
      end
    end
    for (int i = 0; i < 16; i++) r[127-8*i -: 8] = b[i];
    return r ^ k;
  endfunction

  logic [127:0] rks [16];

  task automatic expand_key(input logic [127:0] key);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sb(t[31:24]), sb(t[23:16]), sb(t[15:8]), sb(t[7:0])} ^ {rc, 24'h0};
        rc = xt(rc);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 16; r++) rks[r] = (r <= NR) ? {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]} : 128'h0;
  endtask

  function automatic logic [127:0] aes_enc(input logic [127:0] pt);
    logic [127:0] s;
    s = pt ^ rks[0];
    for (int r = 1; r <= NR; r++) s = aes_round(s, rks[r], r == NR);
    return s;
  endfunction

  // External key store and combinational round datapath.
  assign bus.rk_data   = rks[bus.rk_idx];
  assign bus.dp_result = aes_round(bus.dp_state, bus.rk_data, bus.dp_final);

  // ---------------- scoreboard / monitor ----------------
  logic [127:0] exp_q [$];
  int           acc_q [$];
  int           out_cyc_q [$];
  int           n_out = 0;
  logic         ov_prev = 1'b0;
  logic [127:0] last_ct = '0;

  always @(negedge clk) begin
    int k;
    if (rst_n) begin
      if (acc_q.size() == 0) begin
        chk("idle_rk_idx", 128'(bus.rk_idx), 128'd0);
        chk("idle_dp_final", 128'(bus.dp_final), 128'd0);
        chk("idle_out_valid", 128'(bus.out_valid), 128'd0);
        chk("idle_in_ready", 128'(bus.in_ready), 128'd1);
      end else if (!bus.out_valid) begin
        k = cyc - acc_q[0];
        chk("round_rk_idx", 128'(bus.rk_idx), 128'(k));
        chk("round_dp_final", 128'(bus.dp_final), 128'(k == NR));
        chk("round_in_ready", 128'(bus.in_ready), 128'd0);
      end else begin
        chk("done_in_ready", 128'(bus.in_ready), 128'(bus.out_ready));
        if (!ov_prev) chk("latency", 128'(cyc - acc_q[0]), 128'(NR + 1));
      end
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          chk("spurious_out", 128'd1, 128'd0);
        end else begin
          chk("ciphertext", bus.out_block, exp_q.pop_front());
          void'(acc_q.pop_front());
        end
        last_ct = bus.out_block;
        n_out++;
        out_cyc_q.push_back(cyc);
      end
      if (bus.in_valid && bus.in_ready) begin
        exp_q.push_back(aes_enc(bus.in_block));
        acc_q.push_back(cyc);
      end
      ov_prev = bus.out_valid;
    end else begin
      ov_prev = 1'b0;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic send(input logic [127:0] blk, input bit rnd);
    bit got;
    got = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_block = blk;
    for (int t = 0; t < 200 && !got; t++) begin
      @(negedge clk);
      got = bus.in_valid && bus.in_ready;
      @(posedge clk); #1;
      if (rnd) bus.out_ready = 1'($urandom_range(0, 1));
    end
    bus.in_valid = 1'b0;
    if (!got) chk("send_timeout", 128'd0, 128'd1);
  endtask

  task automatic wait_out(input int target, input bit rnd);
    for (int t = 0; t < 600 && n_out < target; t++) begin
      @(posedge clk); #1;
      if (rnd) bus.out_ready = 1'($urandom_range(0, 1));
    end
    if (n_out < target) chk("out_timeout", 128'(n_out), 128'(target));
  endtask

  task automatic wait_round(input int r);
    bit hit;
    hit = 1'b0;
    for (int t = 0; t < 40 && !hit; t++) begin
      @(negedge clk);
      hit = (int'(bus.rk_idx) == r);
    end
    chk("reach_round", 128'(bus.rk_idx), 128'(r));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  localparam logic [127:0] FIPS_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] FIPS_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] FIPS_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  initial begin
    int n0, nc;
    logic [127:0] blk_a;
    expand_key(FIPS_KEY);
    bus.in_valid  = 1'b0;
    bus.in_block  = '0;
    bus.out_ready = 1'b0;
`ifdef AES_ABORT_EN
    bus.abort     = 1'b0;
`endif

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", 128'(bus.out_valid), 128'd0);
    chk("rst_in_ready", 128'(bus.in_ready), 128'd1);
    chk("rst_rk_idx", 128'(bus.rk_idx), 128'd0);
    chk("rst_dp_final", 128'(bus.dp_final), 128'd0);
    chk("rst_out_block", bus.out_block, 128'd0);
    rst_n = 1'b1;

    // FIPS-197 C.1 known answer
    chk("fips_model", aes_enc(FIPS_PT), FIPS_CT);
    bus.out_ready = 1'b1;
    send(FIPS_PT, 1'b0);
    wait_out(1, 1'b0);
    chk("fips_ct", last_ct, FIPS_CT);

    // Backpressure: ciphertext held 20 cycles, pending block not taken
    bus.out_ready = 1'b0;
    blk_a = 128'h0123456789abcdeffedcba9876543210;
    send(blk_a, 1'b0);
    for (int t = 0; t < 40 && !bus.out_valid; t++) begin
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b1;
    bus.in_block = 128'hdeadbeef00000000cafef00d12345678;
    repeat (20) begin
      @(negedge clk);
      chk("bp_out_valid", 128'(bus.out_valid), 128'd1);
      chk("bp_out_block", bus.out_block, aes_enc(blk_a));
      chk("bp_in_ready", 128'(bus.in_ready), 128'd0);
    end
    n0 = n_out;
    @(posedge clk); #1;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk("bp_single_handshake", 128'(n_out), 128'(n0 + 1));
    chk("bp_out_valid_drop", 128'(bus.out_valid), 128'd0);
    wait_out(n0 + 2, 1'b0);

    // Back-to-back: second block taken on first block's output handshake
    n0 = n_out;
    nc = out_cyc_q.size();
    send(128'h11111111222222223333333344444444, 1'b0);
    send(128'hffeeddccbbaa99887766554433221100, 1'b0);
    wait_out(n0 + 2, 1'b0);
    if (out_cyc_q.size() >= nc + 2)
      chk("b2b_gap", 128'(out_cyc_q[nc+1] - out_cyc_q[nc]), 128'(NR + 1));
    else
      chk("b2b_count", 128'(out_cyc_q.size()), 128'(nc + 2));

    // Reset during round 5
    n0 = n_out;
    send(128'h00000000000000000000000000000001, 1'b0);
    wait_round(5);
    #1;
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", 128'(bus.out_valid), 128'd0);
    chk("midrst_in_ready", 128'(bus.in_ready), 128'd1);
    chk("midrst_rk_idx", 128'(bus.rk_idx), 128'd0);
    chk("midrst_dp_final", 128'(bus.dp_final), 128'd0);
    exp_q.delete();
    acc_q.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    send(128'ha5a5a5a55a5a5a5af0f0f0f00f0f0f0f, 1'b0);
    wait_out(n0 + 1, 1'b0);
    chk("midrst_out_count", 128'(n_out), 128'(n0 + 1));

`ifdef AES_ABORT_EN
    // Abort during round 3: no ciphertext, back to IDLE
    n0 = n_out;
    send(128'h13579bdf02468ace13579bdf02468ace, 1'b0);
    wait_round(3);
    #1;
    bus.abort = 1'b1;
    @(posedge clk); #1;
    bus.abort = 1'b0;
    exp_q.delete();
    acc_q.delete();
    chk("abort_out_valid", 128'(bus.out_valid), 128'd0);
    chk("abort_in_ready", 128'(bus.in_ready), 128'd1);
    chk("abort_rk_idx", 128'(bus.rk_idx), 128'd0);
    repeat (15) @(posedge clk);
    #1;
    chk("abort_no_out", 128'(n_out), 128'(n0));
    send(128'h2468ace013579bdf2468ace013579bdf, 1'b0);
    wait_out(n0 + 1, 1'b0);
`endif

    // Random blocks with random consumer stalls
    n0 = n_out;
    for (int i = 0; i < 5; i++)
      send({$urandom, $urandom, $urandom, $urandom}, 1'b1);
    wait_out(n0 + 5, 1'b1);
    bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("final_pending", 128'(exp_q.size()), 128'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
